// File: rtl/imm_controller.sv
// imm_controller: RV32I immediate assembler.
// Reorders the raw immediate slices of an instruction word into one 20-bit,
// zero-filled immediate chosen by opcode. The combinational result feeds the
// decode stage; a registered copy feeds the next pipeline stage.
module imm_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  Opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [19:0] immA,
    input  logic [11:0] immB,
    input  logic [6:0]  immC,
    input  logic [4:0]  immD,
    output logic [19:0] imm,
    output logic [19:0] imm_q
);

    // RV32I major opcodes that carry an immediate (plus R-type for reference)
    localparam logic [6:0] OpLui      = 7'b0110111;
    localparam logic [6:0] OpAuipc    = 7'b0010111;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpAriItype = 7'b0010011;
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [6:0] OpAriRtype = 7'b0110011;

    typedef enum logic [2:0] {
        FmtNone,
        FmtU,
        FmtJ,
        FmtI,
        FmtB,
        FmtS
    } imm_fmt_e;

    imm_fmt_e    fmt;
    logic [19:0] imm_u;
    logic [19:0] imm_j;
    logic [19:0] imm_i;
    logic [19:0] imm_b;
    logic [19:0] imm_s;
    logic [19:0] imm_d;
    logic [19:0] imm_reg_q;

    // funct fields are deliberately ignored: shift-immediates pass immB whole
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7};

    // Per-format bit reorders; no sign extension, upper bits zero-filled
    assign imm_u = immA;
    assign imm_j = {immA[19], immA[7:0], immA[8], immA[18:9]};
    assign imm_i = {8'b0, immB};
    assign imm_b = {8'b0, immC[6], immD[0], immC[5:0], immD[4:1]};
    assign imm_s = {8'b0, immC, immD};

    // Opcode -> immediate format; unknown or X opcodes fall to FmtNone
    always_comb begin
        fmt = FmtNone;
        case (Opcode)
            OpLui, OpAuipc:             fmt = FmtU;
            OpJal:                      fmt = FmtJ;
            OpJalr, OpLoad, OpAriItype: fmt = FmtI;
            OpBranch:                   fmt = FmtB;
            OpStore:                    fmt = FmtS;
            OpAriRtype:                 fmt = FmtNone;
            default:                    fmt = FmtNone;
        endcase
    end

    // Format select; fmt is always a known value so the output never goes X
    always_comb begin
        imm_d = 20'h00000;
        unique case (fmt)
            FmtU:    imm_d = imm_u;
            FmtJ:    imm_d = imm_j;
            FmtI:    imm_d = imm_i;
            FmtB:    imm_d = imm_b;
            FmtS:    imm_d = imm_s;
            default: imm_d = 20'h00000;
        endcase
    end

    assign imm = imm_d;

    // Pipeline copy: captured every edge, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_reg_q <= 20'h00000;
        end else begin
            imm_reg_q <= imm_d;
        end
    end

    assign imm_q = imm_reg_q;

endmodule

// File: tb/tb_imm_controller.sv
// tb_imm_controller: table vectors plus random loops for imm_controller.
// Expected immediates come from a reference that rebuilds the instruction word
// and extracts the RISC-V immediate fields; imm_q is checked via a scoreboard.
module tb_imm_controller;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;

    logic        clk;
    logic        rst;
    logic [6:0]  Opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] immA;
    logic [11:0] immB;
    logic [6:0]  immC;
    logic [4:0]  immD;
    logic [19:0] imm;
    logic [19:0] imm_q;

    int checks;
    int errors;
    logic [19:0] sb_q[$];

    typedef struct {
        logic [6:0]  op;
        logic [19:0] a;
        logic [11:0] b;
        logic [6:0]  c;
        logic [4:0]  d;
        bit          funct_x;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[12];

    imm_controller u_dut (
        .clk    (clk),
        .rst    (rst),
        .Opcode (Opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .immA   (immA),
        .immB   (immB),
        .immC   (immC),
        .immD   (immD),
        .imm    (imm),
        .imm_q  (imm_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: place slices into a 32-bit instruction, then decode per ISA
    function automatic logic [19:0] ref_imm(input logic [6:0] op, input logic [19:0] a,
                                            input logic [11:0] b, input logic [6:0] c,
                                            input logic [4:0] d);
        logic [31:0] inst_uj;
        logic [31:0] inst_i;
        logic [31:0] inst_sb;
        logic [20:0] jimm;
        logic [12:0] bimm;
        inst_uj = {a, 12'b0};
        inst_i  = {b, 20'b0};
        inst_sb = {c, 13'b0, d, 7'b0};
        jimm    = {inst_uj[31], inst_uj[19:12], inst_uj[20], inst_uj[30:21], 1'b0};
        bimm    = {inst_sb[31], inst_sb[7], inst_sb[30:25], inst_sb[11:8], 1'b0};
        case (op)
            OpLui, OpAuipc:          ref_imm = inst_uj[31:12];
            OpJal:                   ref_imm = jimm[20:1];
            OpJalr, OpLoad, OpItype: ref_imm = {8'b0, inst_i[31:20]};
            OpBranch:                ref_imm = {8'b0, bimm[12:1]};
            OpStore:                 ref_imm = {8'b0, inst_sb[31:25], inst_sb[11:7]};
            default:                 ref_imm = 20'h00000;
        endcase
    endfunction

    task automatic check(input string name, input int id, input logic [19:0] act,
                         input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Drive at negedge, check imm 1 ns later, then check imm_q after next edge
    task automatic apply(input logic [6:0] op, input logic [19:0] a, input logic [11:0] b,
                         input logic [6:0] c, input logic [4:0] d, input bit fx,
                         input logic [19:0] exp, input int id);
        logic [19:0] sb_exp;
        Opcode = op;
        immA   = a;
        immB   = b;
        immC   = c;
        immD   = d;
        funct3 = fx ? 3'bxxx : 3'b000;
        funct7 = fx ? 7'bxxxxxxx : 7'b0000000;
        #1;
        check("imm", id, imm, exp);
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            sb_exp = 20'hxxxxx;
        end else begin
            sb_exp = sb_q.pop_front();
        end
        check("imm_q", id, imm_q, sb_exp);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        Opcode = 7'b0;
        funct3 = 3'b0;
        funct7 = 7'b0;
        immA   = 20'h0;
        immB   = 12'h0;
        immC   = 7'h0;
        immD   = 5'h0;

        vecs[0]  = '{OpLui,    20'hABCDE, 12'h123, 7'h11, 5'h03, 1'b0, 20'hABCDE};
        vecs[1]  = '{OpAuipc,  20'hABCDE, 12'h456, 7'h22, 5'h05, 1'b0, 20'hABCDE};
        vecs[2]  = '{OpJal,    20'hABCDE, 12'h789, 7'h33, 5'h07, 1'b0, 20'hEF15E};
        vecs[3]  = '{OpJalr,   20'h13579, 12'hFFF, 7'h44, 5'h09, 1'b0, 20'h00FFF};
        vecs[4]  = '{OpLoad,   20'h2468A, 12'hFFF, 7'h55, 5'h0B, 1'b0, 20'h00FFF};
        vecs[5]  = '{OpItype,  20'hFEDCB, 12'hFFF, 7'h66, 5'h0D, 1'b0, 20'h00FFF};
        vecs[6]  = '{OpJalr,   20'h13579, 12'hFFF, 7'h44, 5'h09, 1'b1, 20'h00FFF};
        vecs[7]  = '{OpLoad,   20'h2468A, 12'hFFF, 7'h55, 5'h0B, 1'b1, 20'h00FFF};
        vecs[8]  = '{OpItype,  20'hFEDCB, 12'hFFF, 7'h66, 5'h0D, 1'b1, 20'h00FFF};
        vecs[9]  = '{OpBranch, 20'hFFFFF, 12'hFFF, 7'b1010101, 5'b10011, 1'b0, 20'h00D59};
        vecs[10] = '{OpStore,  20'hFFFFF, 12'hFFF, 7'b1010101, 5'b10011, 1'b0, 20'h00AB3};
        vecs[11] = '{OpRtype,  20'hFFFFF, 12'hFFF, 7'h7F, 5'h1F, 1'b0, 20'h00000};

        // Reset state: imm_q held at zero across edges while rst is high
        repeat (2) @(negedge clk);
        check("reset_imm_q", 0, imm_q, 20'h00000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                  vecs[i].funct_x, vecs[i].exp, 100 + i);
        end

        // Unsupported opcodes with random slices produce zero
        for (int i = 0; i < 4; i++) begin
            apply((i % 2 == 0) ? OpRtype : 7'b1111111, 20'($urandom), 12'($urandom),
                  7'($urandom), 5'($urandom), 1'b0, 20'h00000, 200 + i);
        end

        // Random slices through every supported opcode
        for (int loop = 0; loop < 3; loop++) begin
            logic [6:0] ops[8];
            ops = '{OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpItype, OpBranch, OpStore};
            for (int k = 0; k < 8; k++) begin
                logic [19:0] ra;
                logic [11:0] rb;
                logic [6:0]  rc;
                logic [4:0]  rd;
                ra = 20'($urandom);
                rb = 12'($urandom);
                rc = 7'($urandom);
                rd = 5'($urandom);
                apply(ops[k], ra, rb, rc, rd, 1'b0, ref_imm(ops[k], ra, rb, rc, rd),
                      300 + loop * 8 + k);
            end
        end

        // Mid-run reset: imm_q clears without an edge, imm keeps tracking
        apply(OpLui, 20'hABCDE, 12'h0, 7'h0, 5'h0, 1'b0, 20'hABCDE, 400);
        rst = 1'b1;
        #1;
        check("async_rst_imm_q", 401, imm_q, 20'h00000);
        check("rst_imm_tracks", 402, imm, 20'hABCDE);
        @(posedge clk);
        #1;
        check("rst_hold_imm_q", 403, imm_q, 20'h00000);
        @(negedge clk);
        rst = 1'b0;
        apply(OpLui, 20'h12345, 12'h0, 7'h0, 5'h0, 1'b0, 20'h12345, 404);
        check("post_rst_imm", 405, imm, 20'h12345);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
